atm_pin_ctrl: RTL
=================

// Module: atm_pin_ctrl
// PURPOSE
//  PIN-verification sequencer for the ATM front end. Collects keypad digits into internal 4-bit digit registers.
//  Compares the collected PIN against the account's reference PIN and grants or denies the session.
//  Counts failed attempts and locks the terminal after MAX_TRIES failures.
//  Sits between the keypad decoder and the transaction FSM.
// PARAMETERS
//  DIGITS      4     PIN length in BCD digits
//  MAX_TRIES   3     failed attempts allowed before lock (>=1)
//  TIMEOUT_CYC 1000  idle cycles in ENTRY before session abort
//  LOCK_CYC    5000  lockout duration in cycles (used only with ATM_LOCKOUT_TIMER_EN)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          synchronous, active-low reset
//  card_in    in   1          card present (level)
//  key_valid  in   1          one-cycle strobe: key_digit valid
//  key_digit  in   4          BCD digit 0..9
//  key_enter  in   1          one-cycle strobe: submit PIN
//  key_clear  in   1          one-cycle strobe: discard entered digits
//  pin_ref    in   4*DIGITS   reference PIN, digit 0 in [3:0]; sampled in CHECK
//  pin_ok     out  1          level: access granted, held while card_in
//  pin_fail   out  1          one-cycle pulse: wrong PIN
//  timeout    out  1          one-cycle pulse: entry timed out
//  locked     out  1          level: terminal locked
//  digit_cnt  out  clog2(DIGITS+1)  digits currently entered
//  tries_left out  clog2(MAX_TRIES+1)  remaining attempts
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state IDLE, all outputs 0, digit regs 0, tries_left=MAX_TRIES.
//  All outputs are registered.
//  States:
//   IDLE    -> ENTRY when card_in=1 and not locked; digit_cnt=0, idle counter=0.
//   ENTRY   -> key_valid with key_digit<=9 and digit_cnt<DIGITS stores the digit at index digit_cnt; digit_cnt++.
//              Ignored: digits >9 and digits arriving when full.
//              key_clear: digit_cnt=0.
//              key_enter with digit_cnt==DIGITS -> CHECK; key_enter with fewer digits is ignored.
//              Idle counter resets on any accepted strobe.
//              Reaching TIMEOUT_CYC -> IDLE, timeout pulse, digits cleared.
//   CHECK   -> one cycle. Match -> GRANTED, tries_left reloads to MAX_TRIES.
//              Mismatch -> tries_left-1; -> LOCKED if it reaches 0, else DENIED.
//   DENIED  -> pin_fail=1 for this one cycle; -> ENTRY with digit_cnt=0.
//   GRANTED -> pin_ok=1 until card_in=0, then -> IDLE.
//   LOCKED  -> locked=1; card_in ignored; digit regs cleared.
//  Latency: key_enter sampled at edge N; pin_ok or pin_fail is visible after edge N+2.
//  Priority within one cycle: card_in=0 > key_clear > key_valid > key_enter.
//  Exactly one strobe is acted on per cycle; the others are dropped.
//  card_in falling in ENTRY/CHECK/DENIED/GRANTED -> IDLE next edge, digits cleared, no pulse.
//  tries_left persists across card removal; it reloads only on reset, grant, or lock expiry.
//  Reset mid-operation aborts unconditionally to the reset state.
// CONFIGURATION
//  ATM_LOCKOUT_TIMER_EN defined:
//   LOCKED counts LOCK_CYC cycles, then -> IDLE with locked=0 and tries_left=MAX_TRIES.
//  Not defined:
//   LOCKED is permanent until rst; LOCK_CYC is unused and no lock counter is built.
// STRUCTURE
//  Package atm_pkg: state enum (IDLE, ENTRY, CHECK, DENIED, GRANTED, LOCKED) and BCD_MAX=4'd9.
//  Sub-module atm_cycle_timer: loadable down-counter with clear/expire.
//   Instanced once for the entry timeout.
//   Instanced a second time for the lockout, only under ATM_LOCKOUT_TIMER_EN.
// TESTING (DIGITS=4, MAX_TRIES=3, TIMEOUT_CYC=16, LOCK_CYC=32, pin_ref=16'h4321)
//  1. Card in; keys 1,2,3,4; enter -> pin_ok=1 two edges after enter, tries_left=3.
//     Then drop card_in -> pin_ok=0, IDLE.
//  2. Keys 1,2,3,5, enter -> pin_fail pulse, tries_left=2, digit_cnt=0.
//     Then keys 1,2,3,4, enter -> pin_ok=1, tries_left=3.
//  3. Three wrong PINs -> third gives locked=1, tries_left=0, no pin_fail pulse.
//     With macro: locked=0 after 32 cycles. Without macro: locked=1 after 200 cycles.
//  4. Keys 1,2; key_clear+key_valid(7) same cycle -> digit_cnt=0.
//     Then key 'A' -> ignored. Then enter with 3 digits -> ignored.
//  5. Card in, no keys for 16 cycles -> timeout pulse, IDLE.
//     Then remove card mid-ENTRY after 2 digits -> IDLE, digit_cnt=0, no pulse.
//  6. rst=0 for one edge while GRANTED -> all outputs 0, tries_left=3, state IDLE.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN-verification block.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        DENIED,
        GRANTED,
        LOCKED
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/atm_cycle_timer.sv
// Loadable down-counter. load_i (re)arms it to LOAD_CYC-1. While en_i is high it
// counts down. expired_o flags the enabled cycle in which the count sits at zero,
// which is the LOAD_CYC-th enabled cycle after the last load.
module atm_cycle_timer
    import atm_pkg::*;
#(
    parameter int LOAD_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LOAD_CYC + 1);
    localparam logic [W-1:0] RELOAD = W'(LOAD_CYC - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload has priority; otherwise count down while enabled and stop at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register, armed on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/atm_pin_ctrl.sv
// PIN-verification sequencer: collects BCD keypad digits, compares them with the
// reference PIN, grants or denies the session and locks after MAX_TRIES failures.
// Optional macro ATM_LOCKOUT_TIMER_EN: the lock expires after LOCK_CYC cycles.
// Without the macro, the lock lasts until reset.
// Outputs lag the state register by one edge, so a verdict appears two edges after enter.
module atm_pin_ctrl
    import atm_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCK_CYC    = 5000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           card_in,
    input  logic                           key_valid,
    input  logic [3:0]                     key_digit,
    input  logic                           key_enter,
    input  logic                           key_clear,
    input  logic [4*DIGITS-1:0]            pin_ref,
    output logic                           pin_ok,
    output logic                           pin_fail,
    output logic                           timeout,
    output logic                           locked,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] DIGITS_FULL = CW'(DIGITS);
    localparam logic [TW-1:0] TRIES_FULL  = TW'(MAX_TRIES);

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [CW-1:0]        digit_cnt_q, digit_cnt_d;
    logic [TW-1:0]        tries_q, tries_d;
    logic                 timeout_d;
    logic                 pin_ok_q, pin_fail_q, timeout_q, locked_q;
    logic                 strobe_acc;
    logic                 entry_expire;
    logic                 lock_expire;

    atm_cycle_timer #(.LOAD_CYC(TIMEOUT_CYC)) u_entry_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    ((state_q != ENTRY) || strobe_acc),
        .en_i      (state_q == ENTRY),
        .expired_o (entry_expire)
    );

`ifdef ATM_LOCKOUT_TIMER_EN
    atm_cycle_timer #(.LOAD_CYC(LOCK_CYC)) u_lock_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q != LOCKED),
        .en_i      (state_q == LOCKED),
        .expired_o (lock_expire)
    );
`else
    assign lock_expire = 1'b0;
`endif

    // Next state, digit buffer and attempt counter; card removal outranks every strobe
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        digit_cnt_d = digit_cnt_q;
        tries_d     = tries_q;
        timeout_d   = 1'b0;
        strobe_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                digits_d    = '0;
                digit_cnt_d = '0;
                if (card_in) begin
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (!card_in) begin
                    state_d     = IDLE;
                    digits_d    = '0;
                    digit_cnt_d = '0;
                end else if (key_clear) begin
                    digit_cnt_d = '0;
                    strobe_acc  = 1'b1;
                end else if (key_valid) begin
                    if ((key_digit <= BCD_MAX) && (digit_cnt_q < DIGITS_FULL)) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (int'(digit_cnt_q) == i) begin
                                digits_d[i*4 +: 4] = key_digit;
                            end
                        end
                        digit_cnt_d = digit_cnt_q + CW'(1);
                        strobe_acc  = 1'b1;
                    end
                end else if (key_enter) begin
                    if (digit_cnt_q == DIGITS_FULL) begin
                        state_d    = CHECK;
                        strobe_acc = 1'b1;
                    end
                end
                if (card_in && !strobe_acc && entry_expire) begin
                    state_d     = IDLE;
                    digits_d    = '0;
                    digit_cnt_d = '0;
                    timeout_d   = 1'b1;
                end
            end
            CHECK: begin
                digits_d    = '0;
                digit_cnt_d = '0;
                if (!card_in) begin
                    state_d = IDLE;
                end else if (digits_q == pin_ref) begin
                    state_d = GRANTED;
                    tries_d = TRIES_FULL;
                end else if (tries_q <= TW'(1)) begin
                    state_d = LOCKED;
                    tries_d = '0;
                end else begin
                    state_d = DENIED;
                    tries_d = tries_q - TW'(1);
                end
            end
            DENIED: begin
                state_d = card_in ? ENTRY : IDLE;
            end
            GRANTED: begin
                if (!card_in) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                digits_d    = '0;
                digit_cnt_d = '0;
                if (lock_expire) begin
                    state_d = IDLE;
                    tries_d = TRIES_FULL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffer and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            digit_cnt_q <= '0;
            tries_q     <= TRIES_FULL;
            pin_ok_q    <= 1'b0;
            pin_fail_q  <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            digit_cnt_q <= digit_cnt_d;
            tries_q     <= tries_d;
            pin_ok_q    <= (state_q == GRANTED) && card_in;
            pin_fail_q  <= (state_q == DENIED) && card_in;
            timeout_q   <= timeout_d;
            locked_q    <= (state_q == LOCKED) && !lock_expire;
        end
    end

    assign pin_ok     = pin_ok_q;
    assign pin_fail   = pin_fail_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;
    assign digit_cnt  = digit_cnt_q;
    assign tries_left = tries_q;

endmodule
